muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle RV32M execute unit. Consumes the 5-bit ALU_sel codes for MUL/MULH/MULHSU/MULHU/
//  DIV/DIVU/REM/REMU produced by the ALU control decode. Sits beside the ALU in EX.
//  Holds the pipeline via stall while iterating, and returns a 32-bit result with a one-cycle done pulse.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count equals XLEN
// PORTS
//  clk      in   1     rising-edge clock
//  rst      in   1     asynchronous, active-high reset
//  start    in   1     EX holds a valid instruction; sampled only in IDLE
//  ALU_sel  in   5     op code: MUL=00010 MULH=00110 MULHU=01011 MULHSU=01100
//                      DIV=01110 DIVU=10000 REM=10001 REMU=10010; others = not M-op
//  op_a     in   XLEN  rs1 value (multiplicand / dividend)
//  op_b     in   XLEN  rs2 value (multiplier / divisor)
//  flush    in   1     abort the in-flight op (branch/jump flush)
//  busy     out  1     operation in progress (BUSY or DONE state)
//  done     out  1     one-cycle pulse: result valid this cycle
//  result   out  XLEN  M-op result; holds its value until the next done
//  stall    out  1     freeze IF/ID/EX: (start & is_m & IDLE) | (state==BUSY)
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, result=0, stall=0; all internal regs cleared.
//    Reset mid-operation aborts immediately with no done.
//  - FSM states: IDLE -> BUSY -> DONE -> IDLE.
//    IDLE->BUSY on start & is_m (Cycle 0 edge): latch op, |operands|, sign flags; count=0.
//    BUSY: one radix-2 step per cycle. Shift-add for multiply, restoring subtract-shift for divide.
//    At count==XLEN-1 -> DONE. DONE: done=1, result driven from final regs; -> IDLE.
//  - Latency: done high in cycle XLEN+1 after the start edge (33 for XLEN=32), independent of operands.
//    stall deasserts in the DONE cycle so EX/MEM captures result on that edge.
//  - start with non-M ALU_sel: ignored (no state change, stall=0).
//    start while not IDLE: ignored.
//  - Multiply: 2*XLEN product of magnitudes, negated if the sign flags differ.
//    MUL=low XLEN; MULH=high (s*s); MULHSU=high (s*u); MULHU=high (u*u).
//  - Divide: magnitude division, then sign fix. Quotient sign = sign_a^sign_b; remainder sign = sign_a.
//    Unsigned ops treat operands as non-negative.
//  - Divide by zero (op_b==0): DIV/DIVU -> all ones; REM/REMU -> op_a. Same latency.
//  - Signed overflow (DIV/REM with op_a=0x8000_0000, op_b=0xFFFF_FFFF): DIV -> 0x8000_0000; REM -> 0.
//  - flush: in BUSY or DONE, next state IDLE. done is suppressed (flush wins over done in DONE),
//    result unchanged, busy=0 next cycle. flush with start in IDLE: start ignored.
//  - Operands are latched at start; op_a/op_b changes while busy have no effect.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined:
//    MUL/MULH/MULHSU/MULHU use a single combinational XLENxXLEN multiply.
//    IDLE->DONE directly, so done occurs in cycle 1 after start and stall lasts exactly 1 cycle.
//    Divide ops are unchanged.
//  MULDIV_FAST_MUL_EN undefined: all M-ops are iterative with XLEN+1 latency. No hardware multiplier.
// TESTING
//  1. MUL, a=7, b=-3 (0xFFFF_FFFD) -> result=0xFFFF_FFEB. done at cycle 33 (cycle 1 with FAST_MUL).
//  2. MULH a=b=0x8000_0000 -> 0x4000_0000; MULHU same operands -> 0x4000_0000;
//     MULHSU a=0xFFFF_FFFF, b=2 -> 0xFFFF_FFFF.
//  3. DIV a=-7, b=2 -> 0xFFFF_FFFD; REM -> 0xFFFF_FFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
//  4. DIV and REM with b=0, a=0x1234 -> DIV=0xFFFF_FFFF, REM=0x1234.
//     DIV a=0x8000_0000, b=-1 -> 0x8000_0000; REM -> 0.
//  5. Start DIVU, flush at cycle 10 -> busy=0 at cycle 11, no done, result unchanged.
//     rst at cycle 5 of a MUL -> all outputs 0 asynchronously.
//  6. start with ALU_sel=00000 (ADD) -> stall=0, busy=0. Start a new DIV while busy -> ignored;
//     the first result is unaffected.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit beside the EX-stage ALU. It uses radix-2 shift-add and restoring division.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational multiplier.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      ALU_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            stall
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL,
        OP_MULH,
        OP_MULHSU,
        OP_MULHU,
        OP_DIV,
        OP_DIVU,
        OP_REM,
        OP_REMU
    } op_e;

    state_e            state_q;
    op_e               op_q;
    logic [XLEN-1:0]   ma_q;
    logic [XLEN-1:0]   mb_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   fin_q;
    logic [XLEN-1:0]   result_q;
    logic              neg_q;
    logic              neg_r_q;
    logic              bz_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              is_m_c;
    op_e               dec_op;
    logic              dec_sa;
    logic              dec_sb;
    logic              dec_is_div;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;

    logic              op_is_div;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   step_hi_d;
    logic [XLEN-1:0]   step_lo_d;
    logic [XLEN-1:0]   fin_d;

    // Sign-correct a magnitude result; the quotient sits in lo and the remainder in hi.
    function automatic logic [XLEN-1:0] finalize(
        input op_e             op,
        input logic [XLEN-1:0] hi,
        input logic [XLEN-1:0] lo,
        input logic            neg,
        input logic            neg_rem,
        input logic            b_zero
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   res;
        prod = neg ? -{hi, lo} : {hi, lo};
        case (op)
            OP_MUL:                       res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              res = b_zero ? '1 : (neg ? -lo : lo);
            default:                      res = neg_rem ? -hi : hi;
        endcase
        return res;
    endfunction

    always_comb begin
        is_m_c = 1'b1;
        dec_op = OP_MUL;
        dec_sa = 1'b0;
        dec_sb = 1'b0;
        case (ALU_sel)
            5'b00010: begin dec_op = OP_MUL;    dec_sa = 1'b1; dec_sb = 1'b1; end
            5'b00110: begin dec_op = OP_MULH;   dec_sa = 1'b1; dec_sb = 1'b1; end
            5'b01011: begin dec_op = OP_MULHU;                                end
            5'b01100: begin dec_op = OP_MULHSU; dec_sa = 1'b1;                end
            5'b01110: begin dec_op = OP_DIV;    dec_sa = 1'b1; dec_sb = 1'b1; end
            5'b10000: begin dec_op = OP_DIVU;                                 end
            5'b10001: begin dec_op = OP_REM;    dec_sa = 1'b1; dec_sb = 1'b1; end
            5'b10010: begin dec_op = OP_REMU;                                 end
            default:  is_m_c = 1'b0;
        endcase
        dec_is_div = dec_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        neg_a      = dec_sa & op_a[XLEN-1];
        neg_b      = dec_sb & op_b[XLEN-1];
        mag_a      = neg_a ? -op_a : op_a;
        mag_b      = neg_b ? -op_b : op_b;
    end

    // One radix-2 step: shift-add multiply or restoring divide on {hi, lo}.
    always_comb begin
        op_is_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, ma_q} : '0);
        div_trial = {hi_q, lo_q[XLEN-1]};
        div_ge    = (div_trial >= {1'b0, mb_q});
        div_diff  = div_trial[XLEN-1:0] - mb_q;
        if (op_is_div) begin
            step_hi_d = div_ge ? div_diff : div_trial[XLEN-1:0];
            step_lo_d = {lo_q[XLEN-2:0], div_ge};
        end else begin
            step_hi_d = mul_sum[XLEN:1];
            step_lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        fin_d = finalize(op_q, step_hi_d, step_lo_d, neg_q, neg_r_q, bz_q);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_fin;
    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    assign fast_fin  = finalize(dec_op, fast_prod[2*XLEN-1:XLEN], fast_prod[XLEN-1:0],
                                neg_a ^ neg_b, neg_a, 1'b0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            ma_q     <= '0;
            mb_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            fin_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            bz_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && is_m_c && !flush) begin
                        op_q    <= dec_op;
                        ma_q    <= mag_a;
                        mb_q    <= mag_b;
                        hi_q    <= '0;
                        lo_q    <= dec_is_div ? mag_a : mag_b;
                        neg_q   <= neg_a ^ neg_b;
                        neg_r_q <= neg_a;
                        bz_q    <= (op_b == '0);
                        cnt_q   <= '0;
`ifdef MULDIV_FAST_MUL_EN
                        if (!dec_is_div) begin
                            fin_q   <= fast_fin;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_BUSY;
                        end
`else
                        state_q <= S_BUSY;
`endif
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        hi_q  <= step_hi_d;
                        lo_q  <= step_lo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            fin_q   <= fin_d;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!flush) begin
                        result_q <= fin_q;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // A flush in DONE suppresses the pulse and leaves the held result untouched.
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE) && !flush;
    assign result = done ? fin_q : result_q;
    assign stall  = !rst && (((state_q == S_IDLE) && start && is_m_c && !flush) ||
                             (state_q == S_BUSY));

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an arithmetic reference model is compared every cycle, plus hand-computed literals.
module tb_muldiv_unit;

    localparam int unsigned XLEN = 32;
    localparam logic [4:0] SEL_ADD    = 5'b00000;
    localparam logic [4:0] SEL_MUL    = 5'b00010;
    localparam logic [4:0] SEL_MULH   = 5'b00110;
    localparam logic [4:0] SEL_MULHU  = 5'b01011;
    localparam logic [4:0] SEL_MULHSU = 5'b01100;
    localparam logic [4:0] SEL_DIV    = 5'b01110;
    localparam logic [4:0] SEL_DIVU   = 5'b10000;
    localparam logic [4:0] SEL_REM    = 5'b10001;
    localparam logic [4:0] SEL_REMU   = 5'b10010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  sel = 5'b0;
    logic [31:0] a = 32'b0;
    logic [31:0] b = 32'b0;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ALU_sel(sel),
        .op_a   (a),
        .op_b   (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    function automatic logic is_m_sel(input logic [4:0] s);
        return s inside {SEL_MUL, SEL_MULH, SEL_MULHU, SEL_MULHSU,
                         SEL_DIV, SEL_DIVU, SEL_REM, SEL_REMU};
    endfunction

    function automatic logic is_fast(input logic [4:0] s);
`ifdef MULDIV_FAST_MUL_EN
        return s inside {SEL_MUL, SEL_MULH, SEL_MULHU, SEL_MULHSU};
`else
        return (s == 5'b11111) && 1'b0;
`endif
    endfunction

    // RISC-V M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_op(input logic [4:0] s, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, uxs, uys, p;
        logic [63:0]        ux, uy, up;
        logic [31:0]        r;
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        ux  = {32'b0, x};
        uy  = {32'b0, y};
        uxs = ux;
        uys = uy;
        r   = 32'b0;
        case (s)
            SEL_MUL:    begin p = sx * sy;  r = p[31:0];  end
            SEL_MULH:   begin p = sx * sy;  r = p[63:32]; end
            SEL_MULHSU: begin p = sx * uys; r = p[63:32]; end
            SEL_MULHU:  begin up = ux * uy; r = up[63:32]; end
            SEL_DIV: begin
                if (y == 32'b0) r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = sx / sy; r = p[31:0]; end
            end
            SEL_REM: begin
                if (y == 32'b0) r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'b0;
                else begin p = sx % sy; r = p[31:0]; end
            end
            SEL_DIVU: begin
                if (y == 32'b0) r = 32'hFFFF_FFFF;
                else begin up = ux / uy; r = up[31:0]; end
            end
            SEL_REMU: begin
                if (y == 32'b0) r = x;
                else begin p = uxs % uys; r = p[31:0]; end
            end
            default: r = 32'b0;
        endcase
        return r;
    endfunction

    // Reference timeline: cycles left until the result is due, plus held result.
    logic        m_active  = 1'b0;
    int          m_left    = 0;
    logic [31:0] m_pending = 32'b0;
    logic [31:0] m_result  = 32'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active  <= 1'b0;
            m_left    <= 0;
            m_pending <= 32'b0;
            m_result  <= 32'b0;
        end else if (m_active) begin
            if (flush) m_active <= 1'b0;
            else if (m_left == 0) begin
                m_result <= m_pending;
                m_active <= 1'b0;
            end else m_left <= m_left - 1;
        end else if (start && is_m_sel(sel) && !flush) begin
            m_active  <= 1'b1;
            m_left    <= is_fast(sel) ? 0 : int'(XLEN);
            m_pending <= ref_op(sel, a, b);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Compare all outputs against the model at the falling edge.
    task automatic sample();
        logic        e_done, e_stall;
        logic [31:0] e_res;
        @(negedge clk);
        e_done  = m_active && (m_left == 0) && !flush;
        e_stall = !rst && ((!m_active && start && is_m_sel(sel) && !flush) || (m_active && m_left > 0));
        e_res   = e_done ? m_pending : m_result;
        check("cycle{busy,done,stall,result}", {29'b0, busy, done, stall, result},
              {29'b0, m_active, e_done, e_stall, e_res});
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [4:0] s, input logic [31:0] x, input logic [31:0] y,
                          input logic lit, input logic [31:0] exp_v, input int poke_cyc);
        int   cyc;
        int   exp_lat;
        logic got;
        sel = s; a = x; b = y; start = 1'b1;
        sample();
        advance();
        start = 1'b0; sel = SEL_ADD; a = ~x; b = y + 32'd1;
        got = 1'b0;
        cyc = 1;
        exp_lat = is_fast(s) ? 1 : 33;
        while (!got && cyc < 100) begin
            if (cyc == poke_cyc) begin
                start = 1'b1; sel = SEL_DIV; a = 32'd123; b = 32'd5;
            end
            sample();
            if (done) got = 1'b1;
            else begin
                advance();
                start = 1'b0; sel = SEL_ADD;
                cyc++;
            end
        end
        check($sformatf("done_seen sel=%b", s), 64'(got), 64'(1));
        if (got) check($sformatf("latency sel=%b", s), 64'(cyc), 64'(exp_lat));
        if (got && lit) check($sformatf("result sel=%b a=%h b=%h", s, x, y), 64'(result), 64'(exp_v));
        advance();
    endtask

    logic [4:0]  ops [8];
    logic [31:0] pa  [5];
    logic [31:0] pb  [5];
    logic [4:0]  rs_sel;

    initial begin
        ops = '{SEL_MUL, SEL_MULH, SEL_MULHSU, SEL_MULHU, SEL_DIV, SEL_DIVU, SEL_REM, SEL_REMU};
        pa  = '{32'd5, 32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'h8000_0000};
        pb  = '{32'd3, 32'd3,         32'hFFFF_FFFF, 32'h0123_4567, 32'd2};

        #2 rst = 1'b1;
        advance();
        sample();
        check("reset busy",   64'(busy),   64'(0));
        check("reset done",   64'(done),   64'(0));
        check("reset stall",  64'(stall),  64'(0));
        check("reset result", 64'(result), 64'(0));
        advance();
        rst = 1'b0;
        sample();
        advance();

        run_op(SEL_MUL,    32'd7,          32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 0);
        run_op(SEL_MULH,   32'h8000_0000,  32'h8000_0000, 1'b1, 32'h4000_0000, 0);
        run_op(SEL_MULHU,  32'h8000_0000,  32'h8000_0000, 1'b1, 32'h4000_0000, 0);
        run_op(SEL_MULHSU, 32'hFFFF_FFFF,  32'd2,         1'b1, 32'hFFFF_FFFF, 0);
        run_op(SEL_DIV,    32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFD, 0);
        run_op(SEL_REM,    32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFF, 0);
        run_op(SEL_DIVU,   32'd100,        32'd7,         1'b1, 32'd14,        0);
        run_op(SEL_REMU,   32'd100,        32'd7,         1'b1, 32'd2,         0);
        run_op(SEL_DIV,    32'h1234,       32'd0,         1'b1, 32'hFFFF_FFFF, 0);
        run_op(SEL_REM,    32'h1234,       32'd0,         1'b1, 32'h1234,      0);
        run_op(SEL_DIVU,   32'h1234,       32'd0,         1'b1, 32'hFFFF_FFFF, 0);
        run_op(SEL_REMU,   32'h1234,       32'd0,         1'b1, 32'h1234,      0);
        run_op(SEL_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 0);
        run_op(SEL_REM,    32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'd0,         0);
        run_op(SEL_REMU,   32'd100,        32'd7,         1'b1, 32'd2,         0);

        // Flush a DIVU in cycle 10.
        sel = SEL_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        sample();
        advance();
        start = 1'b0; sel = SEL_ADD;
        for (int i = 1; i < 10; i++) begin
            sample();
            advance();
        end
        flush = 1'b1;
        sample();
        advance();
        flush = 1'b0;
        sample();
        check("flush busy",   64'(busy),   64'(0));
        check("flush result", 64'(result), 64'(2));
        begin
            int dcnt;
            dcnt = 0;
            advance();
            for (int i = 0; i < 40; i++) begin
                sample();
                if (done) dcnt++;
                advance();
            end
            check("flush no done", 64'(dcnt), 64'(0));
        end

        // Asynchronous reset in cycle 5 of an iterating op.
        rs_sel = is_fast(SEL_MUL) ? SEL_DIVU : SEL_MUL;
        sel = rs_sel; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
        sample();
        advance();
        start = 1'b0; sel = SEL_ADD;
        for (int i = 1; i < 5; i++) begin
            sample();
            advance();
        end
        check("busy before reset", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("async rst busy",   64'(busy),   64'(0));
        check("async rst done",   64'(done),   64'(0));
        check("async rst stall",  64'(stall),  64'(0));
        check("async rst result", 64'(result), 64'(0));
        sample();
        advance();
        rst = 1'b0;
        sample();
        advance();

        // Non-M opcode is ignored.
        sel = SEL_ADD; a = 32'd1; b = 32'd2; start = 1'b1;
        sample();
        check("add stall", 64'(stall), 64'(0));
        advance();
        start = 1'b0;
        sample();
        check("add busy", 64'(busy), 64'(0));
        advance();

        // A second start while busy must not disturb the first op.
        run_op(SEL_DIV, 32'd100, 32'd7, 1'b1, 32'd14, 3);

        // Flush coinciding with the done cycle.
        sel = SEL_DIVU; a = 32'd9; b = 32'd2; start = 1'b1;
        sample();
        advance();
        start = 1'b0; sel = SEL_ADD;
        for (int i = 1; i < 33; i++) begin
            sample();
            advance();
        end
        flush = 1'b1;
        sample();
        check("flush in done: done",   64'(done),   64'(0));
        check("flush in done: result", 64'(result), 64'(14));
        advance();
        flush = 1'b0;
        sample();
        check("flush in done: busy", 64'(busy), 64'(0));
        advance();

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 5; j++) begin
                run_op(ops[i], pa[j], pb[j], 1'b0, 32'd0, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
